reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Downstream consumer of the reset-request stretcher.
- Turns a stretched reset request, a watchdog bite, or power-good loss into an ordered board reset sequence.
- Sequence: assert PORESET and HRESET together, wait for power-good, release PORESET, then release HRESET after a delay.
- Records the cause of the last reset for the register file.

Parameters:
ASSERT_TICKS, 8'd10, minimum ce ticks with both resets asserted
HRESET_DELAY_TICKS, 8'd5, ce ticks between PORESET release and HRESET release
PG_TIMEOUT_TICKS, 8'd100, ce ticks to wait for pwr_good before entering FAULT

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
ce  input  1  one-cycle timebase tick; all delays count ce, not clk
reset_req  input  1  synchronous level from the reset-request stretcher; rising edge triggers
wdt_reset  input  1  one-cycle watchdog bite pulse
pwr_good  input  1  board power-good, already synchronised
porst_n  output  1  SoC power-on reset, active low
hreset_n  output  1  SoC hard reset, active low
reset_cause  output  2  00 POR, 01 REQ, 10 WDT, 11 PWR
busy  output  1  high while any reset is asserted
fault  output  1  high in FAULT

Behaviour:
- Single clock `clk`; reset is synchronous and active-low on `rst_n`.
- Reset (rst_n low at posedge clk):
  - state=ASSERT, counter=0, reset_cause=00.
  - reset_req edge register=1, so a held request does not re-trigger.
  - Outputs: porst_n=0, hreset_n=0, busy=1, fault=0.
- Outputs are decoded from the registered state (no combinational path from inputs):
  - ASSERT: porst_n=0, hreset_n=0.
  - WAIT_PG: porst_n=0, hreset_n=0.
  - PORST_REL: porst_n=1, hreset_n=0.
  - RUN: porst_n=1, hreset_n=1, busy=0.
  - FAULT: porst_n=0, hreset_n=0, fault=1.
- Counter: 8 bit.
  - Increments on clk when ce=1.
  - Cleared on every state transition.
  - Saturates at 8'hFF, never wraps.
- ASSERT: when counter==ASSERT_TICKS -> WAIT_PG. ce cycles are counted inclusive.
- WAIT_PG:
  - pwr_good=1 -> PORST_REL. This is checked before the timeout.
  - Else counter==PG_TIMEOUT_TICKS -> FAULT.
- PORST_REL:
  - pwr_good=0 -> ASSERT, cause=11.
  - Else counter==HRESET_DELAY_TICKS -> RUN.
- RUN: triggers, highest priority first:
  - pwr_good=0 -> ASSERT, cause=11.
  - wdt_reset=1 -> ASSERT, cause=10.
  - reset_req rising edge (reset_req & ~reset_req_d) -> ASSERT, cause=01.
- FAULT: only a reset_req rising edge -> ASSERT, cause=01. The wdt pulse is ignored.
- Trigger sampling outside RUN/FAULT:
  - wdt_reset and reset_req edges are ignored.
  - reset_req_d is still updated every clk, so a request held across the sequence does not fire on entering RUN.
- Latency: a trigger sampled at clk edge N gives porst_n/hreset_n low after clk edge N+1 (one register stage).
- reset_cause updates on the same edge as the state change into ASSERT and holds until the next trigger. It is not cleared by leaving ASSERT.
- ce high in the same cycle as a transition: the counter is cleared, not incremented.
- Degenerate parameter values:
  - ASSERT_TICKS=0: exit ASSERT after 1 clk.
  - HRESET_DELAY_TICKS=0: release both resets within 2 clk of pwr_good.

Decomposition:
- Shared header/package `reset_seq_pkg` holds:
  - state encodings: ASSERT, WAIT_PG, PORST_REL, RUN, FAULT (3-bit);
  - cause constants CAUSE_POR/REQ/WDT/PWR;
  - counter width 8.
- One natural sub-module, `reset_tick_cnt`: 8-bit ce-gated saturating counter with synchronous clear and compare-equal output.
- Edge detect and FSM stay in the top.

Test Plan:
- Power-on, pwr_good=1, ce every 4 clk:
  - rst_n low 3 clk, then high.
  - porst_n rises after 10 ce + 1 clk.
  - hreset_n rises exactly 5 ce later.
  - reset_cause=00, busy falls with hreset_n.
- In RUN, reset_req 0->1 held for 50 clk:
  - both outputs low on 2nd clk.
  - cause=01, full sequence completes once.
  - no second sequence while reset_req stays high.
- In RUN, wdt_reset pulse and reset_req rising edge in the same clk: cause=10, one sequence.
- pwr_good held 0 after POR:
  - after 10+100 ce, fault=1 and outputs stay low.
  - raising pwr_good alone does not exit.
  - reset_req edge -> ASSERT, cause=01.
- pwr_good drops during PORST_REL:
  - porst_n returns low on the next clk, cause=11.
  - counter restarts; ASSERT lasts a full 10 ce.
- rst_n asserted mid-PORST_REL: outputs low next clk, cause=00, counter=0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the board reset sequencer.
//   state_e        : sequencer states (3-bit encoding)
//   CAUSE_*        : reset_cause encodings reported to the register file
//   CntWidth       : width of the ce tick counter
package reset_seq_pkg;

  localparam int unsigned CntWidth = 8;

  typedef enum logic [2:0] {
    StAssert   = 3'd0,
    StWaitPg   = 3'd1,
    StPorstRel = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_REQ = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;
  localparam logic [1:0] CAUSE_PWR = 2'b11;

endpackage

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its surroundings.
//   ce, reset_req, wdt_reset, pwr_good : into the sequencer
//   porst_n, hreset_n                  : active-low SoC resets out of the sequencer
//   reset_cause, busy, fault           : status out of the sequencer
// slave is the sequencer side, master drives the inputs and observes the outputs.
interface reset_sequencer_if;
  logic       ce;
  logic       reset_req;
  logic       wdt_reset;
  logic       pwr_good;
  logic       porst_n;
  logic       hreset_n;
  logic [1:0] reset_cause;
  logic       busy;
  logic       fault;

  modport master (
    output ce, reset_req, wdt_reset, pwr_good,
    input  porst_n, hreset_n, reset_cause, busy, fault
  );

  modport slave (
    input  ce, reset_req, wdt_reset, pwr_good,
    output porst_n, hreset_n, reset_cause, busy, fault
  );
endinterface

// File: rtl/reset_tick_cnt.sv
// ce-gated saturating tick counter with synchronous clear and compare-equal flag.
//   clk, rst_n : clock, synchronous active-low reset
//   ce_i       : timebase tick, counter advances only when high
//   clr_i      : synchronous clear, wins over ce_i
//   cmp_i      : compare value
//   eq_o       : registered count equals cmp_i
module reset_tick_cnt
  import reset_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce_i,
  input  logic                clr_i,
  input  logic [CntWidth-1:0] cmp_i,
  output logic                eq_o
);

  logic [CntWidth-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ce_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq_o = (cnt_q == cmp_i);

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: turns a reset request edge, watchdog bite or power-good
// loss into ASSERT -> WAIT_PG -> PORST_REL -> RUN, and records the last cause.
//   clk, rst_n : clock, synchronous active-low reset (restarts as a POR)
//   bus        : reset_sequencer_if slave (inputs ce/reset_req/wdt_reset/pwr_good,
//                outputs porst_n/hreset_n/reset_cause/busy/fault)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter logic [CntWidth-1:0] ASSERT_TICKS       = 8'd10,
  parameter logic [CntWidth-1:0] HRESET_DELAY_TICKS = 8'd5,
  parameter logic [CntWidth-1:0] PG_TIMEOUT_TICKS   = 8'd100
) (
  input logic               clk,
  input logic               rst_n,
  reset_sequencer_if.slave  bus
);

  state_e              state_d, state_q;
  logic [1:0]          cause_d, cause_q;
  logic                req_q;
  logic                req_rise;
  logic                cnt_eq;
  logic [CntWidth-1:0] cnt_cmp;

  // req_q tracks reset_req every cycle so a request held through a sequence
  // cannot fire when RUN is reached.
  assign req_rise = bus.reset_req & ~req_q;

  always_comb begin
    cnt_cmp = '0;
    unique case (state_q)
      StAssert:   cnt_cmp = ASSERT_TICKS;
      StWaitPg:   cnt_cmp = PG_TIMEOUT_TICKS;
      StPorstRel: cnt_cmp = HRESET_DELAY_TICKS;
      default:    cnt_cmp = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      StAssert: begin
        if (cnt_eq) state_d = StWaitPg;
      end
      StWaitPg: begin
        if (bus.pwr_good)  state_d = StPorstRel;
        else if (cnt_eq)   state_d = StFault;
      end
      StPorstRel: begin
        if (!bus.pwr_good) begin
          state_d = StAssert;
          cause_d = CAUSE_PWR;
        end else if (cnt_eq) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!bus.pwr_good) begin
          state_d = StAssert;
          cause_d = CAUSE_PWR;
        end else if (bus.wdt_reset) begin
          state_d = StAssert;
          cause_d = CAUSE_WDT;
        end else if (req_rise) begin
          state_d = StAssert;
          cause_d = CAUSE_REQ;
        end
      end
      StFault: begin
        if (req_rise) begin
          state_d = StAssert;
          cause_d = CAUSE_REQ;
        end
      end
      default: state_d = StAssert;
    endcase
  end

  // Clearing on any transition also drops a coincident ce tick.
  reset_tick_cnt u_tick_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ce_i  (bus.ce),
    .clr_i (state_d != state_q),
    .cmp_i (cnt_cmp),
    .eq_o  (cnt_eq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StAssert;
      cause_q <= CAUSE_POR;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      req_q   <= bus.reset_req;
    end
  end

  always_comb begin
    bus.porst_n  = 1'b0;
    bus.hreset_n = 1'b0;
    bus.busy     = 1'b1;
    bus.fault    = 1'b0;
    unique case (state_q)
      StPorstRel: bus.porst_n = 1'b1;
      StRun: begin
        bus.porst_n  = 1'b1;
        bus.hreset_n = 1'b1;
        bus.busy     = 1'b0;
      end
      StFault: bus.fault = 1'b1;
      default: ;
    endcase
  end

  assign bus.reset_cause = cause_q;

endmodule
